// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front-end: fetch FSM states, MIPS opcodes
// and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Opcode field of a 32-bit instruction word.
  function automatic logic [5:0] get_op(logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump, then taken branch, then pc+4.
// All arithmetic wraps modulo 2^WIDTH.
module next_pc_logic #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] instr,
  input  logic             branch,
  input  logic             ne,
  input  logic             zero,
  input  logic             jump,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc_plus4
);

  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] jump_target;
  logic             br_taken;
  logic             unused_instr;

  // Opcode bits are decoded elsewhere; only the immediate fields matter here.
  assign unused_instr = ^instr[WIDTH-1:26];

  assign pc_plus4    = pc + WIDTH'(4);
  assign br_offset   = {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
  assign jump_target = {pc_plus4[WIDTH-1:28], instr[25:0], 2'b00};
  // ne flips the sense of zero so one comparator serves both BEQ and BNE.
  assign br_taken    = branch & (zero ^ ne);

  // Priority select of the next PC.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (br_taken) begin
      next_pc = pc_plus4 + br_offset;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: holds the PC, fetches over a req/ready bus, latches the word
// and advances the PC when the back-end retires the instruction.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.master     imem,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic             instr_valid,
  input  logic             branch,
  input  logic             ne,
  input  logic             jump,
  input  logic             zero,
  input  logic             retire,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [31:0]      wait_cnt
`endif
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] next_pc;
  logic             req;

  next_pc_logic #(
    .WIDTH (WIDTH)
  ) u_next_pc_logic (
    .pc       (pc_q),
    .instr    (instr_q),
    .branch   (branch),
    .ne       (ne),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // State, PC and instruction registers; reset forces IDLE so a late ready is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Fetch FSM next state, instruction latch and PC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = VALID;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (retire) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign op             = get_op(instr_q[31:0]);
  assign instr_valid    = (state_q == VALID);
  assign pc             = pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] wait_q;

  // Retired-instruction and memory-wait-cycle counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      if (state_q == VALID && retire) begin
        retired_q <= retired_q + 32'd1;
      end
      if (state_q == WAIT) begin
        wait_q <= wait_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign wait_cnt    = wait_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan steps, a randomized
// run against an instruction-level reference model, and direct vectors on
// the next_pc_logic sub-module.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  op;
  logic        instr_valid;
  logic        branch, ne, jump, zero, retire;
`ifdef FETCH_PERF_EN
  logic [31:0] retired_cnt, wait_cnt;
`endif

  fetch_unit_if #(.WIDTH(32)) imem ();

  fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .branch      (branch),
    .ne          (ne),
    .jump        (jump),
    .zero        (zero),
    .retire      (retire),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .wait_cnt    (wait_cnt)
`endif
  );

  // Stand-alone instance of the next-PC block for direct vectors.
  logic [31:0] u_pc, u_instr, u_next, u_plus4;
  logic        u_branch, u_ne, u_zero, u_jump;

  next_pc_logic #(.WIDTH(32)) u_npc (
    .pc       (u_pc),
    .instr    (u_instr),
    .branch   (u_branch),
    .ne       (u_ne),
    .zero     (u_zero),
    .jump     (u_jump),
    .next_pc  (u_next),
    .pc_plus4 (u_plus4)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: one in-flight instruction at a time.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_have;     // a fetched, unretired word is held
  logic        m_started;  // first cycle after reset release has passed
  int          m_req_age;  // cycles the current request has been outstanding
  logic [31:0] m_waits;
  logic [31:0] m_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic b, input logic n, input logic j,
                                           input logic z);
    logic [31:0] p4;
    int          off;
    p4  = p + 32'd4;
    off = int'($signed(w[15:0]));
    if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && (z != n)) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic model_reset();
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_have    = 1'b0;
    m_started = 1'b0;
    m_req_age = 0;
    m_waits   = 32'h0;
    m_retired = 32'h0;
  endtask

  // One clock cycle: check outputs at the negedge, drive inputs, advance the model.
  task automatic step(input logic rdy, input logic [31:0] rdata, input logic ret,
                      input logic br, input logic n, input logic j, input logic z);
    logic exp_req;
    exp_req = m_started && !m_have;
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
    check("imem_req", {31'b0, imem.imem_req}, {31'b0, exp_req});
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr", instr, m_instr);
    check("op", {26'b0, op}, m_instr >> 26);
    if (exp_req) check("imem_addr", imem.imem_addr, m_pc);
`ifdef FETCH_PERF_EN
    check("wait_cnt", wait_cnt, m_waits);
    check("retired_cnt", retired_cnt, m_retired);
`endif
    imem.imem_ready = rdy;
    imem.imem_rdata = rdata;
    retire = ret;
    branch = br;
    ne     = n;
    jump   = j;
    zero   = z;
    if (exp_req) begin
      if (m_req_age != 0) m_waits = m_waits + 32'd1;
      if (rdy) begin
        m_have    = 1'b1;
        m_instr   = rdata;
        m_req_age = 0;
      end else begin
        m_req_age++;
      end
    end else if (m_have && ret) begin
      m_pc      = ref_next(m_pc, m_instr, br, n, j, z);
      m_have    = 1'b0;
      m_retired = m_retired + 32'd1;
    end
    m_started = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic unit_vec(input string tag, input logic [31:0] p, input logic [31:0] w,
                          input logic b, input logic n, input logic z, input logic j,
                          input logic [31:0] exp);
    u_pc = p; u_instr = w; u_branch = b; u_ne = n; u_zero = z; u_jump = j;
    #1;
    check(tag, u_next, exp);
    check({tag, "_p4"}, u_plus4, p + 32'd4);
  endtask

  logic [5:0]  ops [5];
  logic [31:0] rnd;

  initial begin
    ops[0] = 6'b001000; ops[1] = 6'b000100; ops[2] = 6'b000101;
    ops[3] = 6'b000010; ops[4] = 6'b000000;
    reset = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
    {branch, ne, jump, zero, retire} = '0;
    model_reset();

    // Reset state, held while reset is low.
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_req", {31'b0, imem.imem_req}, 32'h0);
    reset = 1'b1;

    // Zero-wait memory, immediate retire: one instruction every two cycles.
    repeat (7) step(1'b1, 32'h2008_0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_pc", pc, 32'd12);
    check("seq_op", {26'b0, op}, 32'h08);

    // Three wait cycles before ready; address must stay put throughout.
    repeat (3) step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2008_0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wait_latch", instr, 32'h2008_0007);
    check("wait_total", m_waits, 32'd3);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in WAIT: req drops at once and a late ready is ignored.
    #2 reset = 1'b0;
    #1;
    check("abort_req", {31'b0, imem.imem_req}, 32'h0);
    check("abort_pc", pc, 32'h0);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("abort_instr", instr, 32'h0);
    check("abort_valid", {31'b0, instr_valid}, 32'h0);
    @(negedge clk);
    imem.imem_ready = 1'b0;
    model_reset();
    reset = 1'b1;
    repeat (3) step(1'b1, 32'h2008_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_pc", pc, 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom();
      step(($urandom_range(0, 2) != 0), {ops[$urandom_range(0, 4)], rnd[25:0]},
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 1) == 1));
    end

    // Direct next-PC vectors.
    unit_vec("beq_taken", 32'h10, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10);
    unit_vec("beq_not", 32'h10, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h14);
    unit_vec("bne_taken", 32'h20, 32'h1400_0002, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2C);
    unit_vec("bne_not", 32'h20, 32'h1400_0002, 1'b1, 1'b1, 1'b1, 1'b0, 32'h24);
    unit_vec("j_prio", 32'h8000_0000, 32'h0800_0040, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0100);
    unit_vec("pc_wrap", 32'hFFFF_FFFC, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    unit_vec("br_wrap", 32'h0, 32'h1000_FFF0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFC4);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] rp, rw;
      logic        rb, rn, rz, rj;
      rp = $urandom() & 32'hFFFF_FFFC;
      rw = $urandom();
      {rb, rn, rz, rj} = 4'($urandom());
      unit_vec("npc_rand", rp, rw, rb, rn, rz, rj, ref_next(rp, rw, rb, rn, rj, rz));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream neighbour of the main decoder: holds the PC, fetches from a variable-latency instruction memory through a req/ready handshake, and latches the instruction word.
- Presents the instruction and its opcode field to the decoder.
- Computes next PC from decoder controls (branch, ne, jump) and the ALU zero flag, and advances only when the back-end signals retire.

Parameters:
- WIDTH, 32, data/address width in bits.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  WIDTH  fetch address = pc; stable while imem_req=1.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  WIDTH  instruction word.
- instr  out  WIDTH  latched instruction.
- op  out  6  instr[31:26], to decoder.
- instr_valid  out  1  instr holds a fetched, not-yet-retired instruction.
- branch, ne, jump  in  1 each  decoder controls for the current instr.
- zero  in  1  ALU zero flag for the current instr.
- retire  in  1  back-end finished current instr; sampled only when instr_valid=1.
- pc  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc+4, for JAL-style consumers.

Behaviour:
- Reset (async, reset=0): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0. All outputs are held there while reset is low.
- FSM IDLE -> REQ: unconditional, on the first edge after reset release.
- FSM REQ: imem_req=1, imem_addr=pc.
  - imem_ready=1: instr<=imem_rdata, go VALID.
  - imem_ready=0: go WAIT.
- FSM WAIT: imem_req=1, same address. On imem_ready=1: latch instr, go VALID.
- FSM VALID: instr_valid=1, imem_req=0, imem_ready ignored.
  - retire=1: pc<=next_pc, instr_valid drops next cycle, go REQ.
  - retire=0: hold pc and instr indefinitely.
- Minimum latency: 2 cycles per instruction (REQ with zero-wait memory, then VALID with immediate retire).
- next_pc, combinational, in priority order:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch & (zero ^ ne): pc_plus4 + (sign-extended instr[15:0] << 2).
  - else pc_plus4.
- Arithmetic is modulo 2^WIDTH. pc 32'hFFFF_FFFC + 4 wraps to 0, and branch targets wrap silently.
- jump and branch both 1: jump wins.
- branch/ne/jump/zero are ignored outside VALID.
- imem_addr[1:0] is always 00. No misalignment trap.
- Reset during WAIT or VALID aborts immediately: imem_req falls asynchronously, and any late imem_ready is ignored because the state is IDLE.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports retired_cnt (32) and wait_cnt (32), both reset to 0.
  - retired_cnt increments on each VALID&retire.
  - wait_cnt increments each cycle in WAIT.
  - Both wrap at 2^32.
- Undefined: these ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, VALID}.
  - opcode localparams (OP_RTYPE=6'b000000, OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_J=6'b000010, …).
  - default RESET_PC.
- One sub-module: next_pc_logic, purely combinational.
  - Inputs: pc, instr, branch, ne, zero, jump.
  - Outputs: next_pc, pc_plus4.
  - Unit-testable separately.

Test Plan:
- Release reset with imem_ready tied 1 and retire tied 1, instr=32'h2008_0005 (ADDI) -> imem_addr 0,4,8 on every second cycle; instr_valid pulses each alternate cycle.
- imem_ready held 0 for 3 cycles -> imem_req=1 and imem_addr constant for 4 cycles; instr latched on the ready cycle; wait_cnt=3 when FETCH_PERF_EN is defined.
- BEQ: pc=0x10, instr=32'h1000_FFFF, branch=1, zero=1, ne=0 -> next pc=0x10; same with zero=0 -> 0x14.
- BNE: ne=1, zero=0, offset 2 at pc=0x20 -> next pc 0x2C.
- J with instr[25:0]=26'h0000040 at pc=0x8000_0000 and branch also asserted -> next pc 0x8000_0100 (jump priority).
- Reset asserted mid-WAIT, then imem_ready pulsed -> imem_req 0 immediately, instr unchanged (0); after release, fetch restarts at RESET_PC.
- Additional wrap check: pc=0xFFFF_FFFC, plain retire -> pc=0.
